// File: rtl/freq_meter_hertz.sv
// Gate-window frequency meter: counts synchronized rising edges of sigIn per GATE_CYCLES window.
// Optional period measurement between consecutive rising edges when FREQ_METER_PERIOD_EN is defined.
module freq_meter_hertz #(
    parameter int unsigned CLK_FREQ    = 12000000,
    parameter int unsigned GATE_HZ     = 1,
    parameter int unsigned COUNT_WIDTH = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   enable,
    input  logic                   sigIn,
    output logic [COUNT_WIDTH-1:0] edgeCount,
    output logic                   countValid,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] periodCycles,
    output logic                   periodValid
);

    localparam int unsigned GATE_CYCLES = CLK_FREQ / GATE_HZ;
    localparam int unsigned GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_c;

    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d, acc_sum;
    logic                   sat_q, sat_d, sat_sum;
    logic [COUNT_WIDTH-1:0] edge_count_q, edge_count_d;
    logic                   count_valid_q, count_valid_d;
    logic                   overflow_q, overflow_d;

    // Input synchronizer and rising-edge detect; runs independently of enable
    always_ff @(posedge clk) begin
        if (!nRst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sigIn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Gate window, accumulator and result publication
    always_comb begin
        gate_d        = gate_q;
        acc_d         = acc_q;
        sat_d         = sat_q;
        edge_count_d  = edge_count_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;
        acc_sum       = acc_q;
        sat_sum       = sat_q;

        if (edge_c) begin
            if (acc_q == COUNT_MAX) begin
                sat_sum = 1'b1;
            end else begin
                acc_sum = acc_q + COUNT_WIDTH'(1);
            end
        end

        if (!enable) begin
            gate_d = '0;
            acc_d  = '0;
            sat_d  = 1'b0;
        end else if (gate_q == GATE_LAST) begin
            // Terminal cycle: an edge landing here still belongs to the closing window
            gate_d        = '0;
            edge_count_d  = acc_sum;
            overflow_d    = sat_sum;
            count_valid_d = 1'b1;
            acc_d         = '0;
            sat_d         = 1'b0;
        end else begin
            gate_d = gate_q + GATE_W'(1);
            acc_d  = acc_sum;
            sat_d  = sat_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            gate_q        <= '0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            edge_count_q  <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            gate_q        <= gate_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            edge_count_q  <= edge_count_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign edgeCount  = edge_count_q;
    assign countValid = count_valid_q;
    assign overflow   = overflow_q;

`ifdef FREQ_METER_PERIOD_EN
    logic [COUNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   seen_q, seen_d;
    logic                   pvalid_q, pvalid_d;

    // Cycles between consecutive rising edges; the first edge after enable only arms it
    always_comb begin
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        seen_d    = seen_q;
        pvalid_d  = 1'b0;

        if (!enable) begin
            per_cnt_d = '0;
            period_d  = '0;
            seen_d    = 1'b0;
        end else if (edge_c) begin
            per_cnt_d = COUNT_WIDTH'(1);
            seen_d    = 1'b1;
            if (seen_q) begin
                period_d = per_cnt_q;
                pvalid_d = 1'b1;
            end
        end else if (per_cnt_q != COUNT_MAX) begin
            per_cnt_d = per_cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            seen_q    <= 1'b0;
            pvalid_q  <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            seen_q    <= seen_d;
            pvalid_q  <= pvalid_d;
        end
    end

    assign periodCycles = period_q;
    assign periodValid  = pvalid_q;
`else
    assign periodCycles = '0;
    assign periodValid  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter_hertz.sv
// Directed bench for freq_meter_hertz with GATE_CYCLES=100; a 4-bit instance shares the stimulus.
module tb_freq_meter_hertz;

    logic        clk;
    logic        nRst;
    logic        enable;
    logic        sigIn;

    logic [23:0] edgeCount;
    logic        countValid;
    logic        overflow;
    logic [23:0] periodCycles;
    logic        periodValid;

    logic [3:0]  edgeCount4;
    logic        countValid4;
    logic        overflow4;
    logic [3:0]  periodCycles4;
    logic        periodValid4;

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int t1 = 0;
    int pv_base = 0;

    int   cyc = 0;
    int   npulse = 0;
    int   last_pulse = -1;
    int   wide = 0;
    int   pv_n = 0;
    int   last_pv = 0;
    int   prev_pv = 0;
    logic cv_prev = 1'b0;

    freq_meter_hertz #(
        .CLK_FREQ(100), .GATE_HZ(1), .COUNT_WIDTH(24), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .nRst(nRst), .enable(enable), .sigIn(sigIn),
        .edgeCount(edgeCount), .countValid(countValid), .overflow(overflow),
        .periodCycles(periodCycles), .periodValid(periodValid)
    );

    freq_meter_hertz #(
        .CLK_FREQ(100), .GATE_HZ(1), .COUNT_WIDTH(4), .SYNC_STAGES(2)
    ) u_dut4 (
        .clk(clk), .nRst(nRst), .enable(enable), .sigIn(sigIn),
        .edgeCount(edgeCount4), .countValid(countValid4), .overflow(overflow4),
        .periodCycles(periodCycles4), .periodValid(periodValid4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle record of result and period pulses, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (countValid === 1'b1) begin
            npulse++;
            last_pulse = cyc;
            if (cv_prev) wide++;
        end
        cv_prev = (countValid === 1'b1);
        if (periodValid === 1'b1) begin
            pv_n++;
            prev_pv = last_pv;
            last_pv = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive sigIn for n cycles: high for the first 'high' cycles of each period, plus one extra pulse
    task automatic drive_wave(input int n, input int period, input int high, input int extra);
        for (int i = 0; i < n; i++) begin
            sigIn = (((i % period) < high) || (i == extra));
            @(negedge clk);
        end
    endtask

    task automatic chk_window(input int exp_time, input int exp_n, input int exp_cnt,
                              input int exp_ovf, input int exp_cnt4, input int exp_ovf4);
        chk("countValid", 32'(countValid), 32'd1);
        chk("pulse_time", 32'(last_pulse), 32'(exp_time));
        chk("pulse_count", 32'(npulse), 32'(exp_n));
        chk("edgeCount", 32'(edgeCount), 32'(exp_cnt));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("countValid4", 32'(countValid4), 32'd1);
        chk("edgeCount4", 32'(edgeCount4), 32'(exp_cnt4));
        chk("overflow4", 32'(overflow4), 32'(exp_ovf4));
    endtask

    initial begin
        nRst   = 1'b0;
        enable = 1'b1;
        sigIn  = 1'b0;

        // Reset held with sigIn toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sigIn = ((i % 2) == 0);
        end
        chk("rst_edgeCount", 32'(edgeCount), 32'd0);
        chk("rst_countValid", 32'(countValid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_periodCycles", 32'(periodCycles), 32'd0);
        chk("rst_periodValid", 32'(periodValid), 32'd0);
        chk("rst_edgeCount4", 32'(edgeCount4), 32'd0);
        chk("rst_pulses", 32'(npulse), 32'd0);

        @(negedge clk);
        nRst = 1'b1;
        t0   = cyc;

        // Windows 1-2: period 10 square wave
        drive_wave(100, 10, 5, -1);
        chk_window(t0 + 100, 1, 10, 0, 10, 0);
`ifdef FREQ_METER_PERIOD_EN
        chk("w1_period_pulses", 32'(pv_n), 32'd9);
        chk("w1_periodCycles", 32'(periodCycles), 32'd10);
`endif
        drive_wave(100, 10, 5, -1);
        chk_window(t0 + 200, 2, 10, 0, 10, 0);
        chk("pulse_width", 32'(wide), 32'd0);

        // Window 3: no edges, result still published
        drive_wave(100, 1, 0, -1);
        chk_window(t0 + 300, 3, 0, 0, 0, 0);

        // Window 4: extra edge detected on the terminal cycle
        drive_wave(100, 10, 5, 97);
        chk_window(t0 + 400, 4, 11, 0, 11, 0);

        // Window 5: 25 edges saturate the 4-bit instance
        drive_wave(100, 4, 2, -1);
        chk_window(t0 + 500, 5, 25, 0, 15, 1);

        // Window 6: back to 10 edges, overflow clears
        drive_wave(100, 10, 5, -1);
        chk_window(t0 + 600, 6, 10, 0, 10, 0);

        // Window 7 interrupted at cycle 50 for 20 cycles
        drive_wave(50, 10, 5, -1);
        enable = 1'b0;
        drive_wave(20, 1, 0, -1);
        chk("gap_countValid", 32'(countValid), 32'd0);
        chk("gap_pulses", 32'(npulse), 32'd6);
        chk("gap_edgeCount", 32'(edgeCount), 32'd10);
        chk("gap_edgeCount4", 32'(edgeCount4), 32'd10);
        enable = 1'b1;
        t1     = cyc;
        drive_wave(100, 5, 2, -1);
        chk_window(t1 + 100, 7, 20, 0, 15, 1);
        chk("pulse_width_end", 32'(wide), 32'd0);

        // Period 7 input
        pv_base = pv_n;
        drive_wave(49, 7, 3, -1);
`ifdef FREQ_METER_PERIOD_EN
        chk("p7_periodCycles", 32'(periodCycles), 32'd7);
        chk("p7_pulses", 32'(pv_n - pv_base), 32'd7);
        chk("p7_spacing", 32'(last_pv - prev_pv), 32'd7);
`else
        chk("p_periodCycles", 32'(periodCycles), 32'd0);
        chk("p_periodValid", 32'(periodValid), 32'd0);
        chk("p_pulses", 32'(pv_n), 32'd0);
        chk("p_periodCycles4", 32'(periodCycles4), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meter_hertz.md
Name: freq_meter_hertz

Overview:
- Measures the frequency of an external digital signal, the input-side counterpart of the Hz clock divider.
- Counts rising edges of an asynchronous input over a fixed gate window derived from the system clock, and publishes the count once per window.
- Used for bring-up checks of external oscillators and divider outputs on the iCE40 board, and to feed UART and LED status logic.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- GATE_HZ, 1, gate windows per second; GATE_CYCLES = CLK_FREQ/GATE_HZ, must be >= 2.
- COUNT_WIDTH, 24, width of the edge count result.
- SYNC_STAGES, 2, synchronizer flops on sigIn, must be >= 2.

Ports:
- clk  input  1  system clock.
- nRst  input  1  synchronous active-low reset.
- enable  input  1  high = measure; low = gate and accumulator held cleared.
- sigIn  input  1  asynchronous signal under measurement.
- edgeCount  output  COUNT_WIDTH  rising edges counted in the last complete window (saturating).
- countValid  output  1  one-cycle pulse when edgeCount updates.
- overflow  output  1  last completed window saturated.
- periodCycles  output  COUNT_WIDTH  optional feature, see below.
- periodValid  output  1  optional feature, see below.

Behaviour:
- Reset (nRst low at a clk edge): synchronizer, edge-detect register, gate counter, accumulator, edgeCount, countValid, overflow, periodCycles and periodValid all go to 0. Reset takes priority over enable and any window in progress.
- Synchronizer: SYNC_STAGES flops.
  - A rising edge is detected when the sync output is 1 and the previous-sample register is 0.
  - Detection latency is SYNC_STAGES+1 cycles. Edges in flight at a window boundary count toward the next window, which is accepted.
  - The synchronizer runs regardless of enable.
- Gate counter: counts 0..GATE_CYCLES-1 while enable=1, then wraps to 0. The cycle with gateCnt==GATE_CYCLES-1 is the terminal cycle.
- Accumulator:
  - Increments by 1 on each detected edge while enable=1.
  - Saturates at 2^COUNT_WIDTH-1, setting an internal sat flag.
- Terminal cycle, registered on that clk edge:
  - edgeCount <= accumulator plus that cycle's edge, saturated.
  - overflow <= sat, including saturation caused by that final increment.
  - countValid <= 1.
  - Accumulator and sat cleared to 0, so the next window starts empty.
- countValid is high for exactly one cycle per window and low otherwise.
- Window cadence: results appear every GATE_CYCLES cycles. The first result appears GATE_CYCLES cycles after enable rises or nRst is released with enable=1.
- enable low:
  - Gate counter, accumulator and sat held at 0.
  - edgeCount and overflow keep their last values; countValid stays 0.
  - A window interrupted by enable low is discarded, never published.
- Edge and terminal in the same cycle: the edge counts in the closing window.
- Maximum measurable input: clk/2 toggle rate. Faster inputs alias, which is acceptable.

Optional Feature:
- Macro: FREQ_METER_PERIOD_EN.
- Defined:
  - A free-running cycle counter restarts at 1 on each detected rising edge and saturates at 2^COUNT_WIDTH-1.
  - On each rising edge after the first since reset or enable rising, periodCycles <= counter value (clk cycles between the last two rising edges) and periodValid pulses for 1 cycle.
  - Held cleared while enable=0.
- Undefined: periodCycles and periodValid are tied to 0 and no period logic is synthesized. Ports remain for a fixed interface.

Test Plan:
All scenarios use CLK_FREQ=100, GATE_HZ=1 (GATE_CYCLES=100) unless noted.
- Reset: nRst low 5 cycles with sigIn toggling -> all outputs 0, no countValid; after release with enable=1, first countValid exactly 100 cycles later.
- sigIn square wave, period 10 clk, enable=1 -> every window edgeCount=10, overflow=0, countValid pulses once every 100 cycles, width 1.
- sigIn held 0 for a full window -> edgeCount=0, countValid still pulses. Edge placed on the terminal cycle -> counted in the closing window (10 -> 11).
- COUNT_WIDTH=4, sigIn period 4 clk (25 edges) -> edgeCount=15, overflow=1; next window period 10 -> edgeCount=10, overflow=0.
- enable dropped at cycle 50 of a window for 20 cycles -> no countValid for that window, edgeCount keeps the prior value 10; next countValid exactly 100 cycles after enable re-rises.
- FREQ_METER_PERIOD_EN defined, sigIn period 7 clk -> periodCycles=7, periodValid pulses every 7 cycles starting from the second edge. Undefined -> both outputs are constantly 0.
